// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one result bit per cycle, fixed latency.
// Ports: CLK, Reset(async high), start/op/operand_a/operand_b/rd_in/kill in; busy/done/result/rd_out/wb_en out.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [ADDR_W-1:0] rd_out,
  output logic              wb_en
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              neg_q, neg_d;
  logic              nrem_q, nrem_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] rd_out_q, rd_out_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              done_q, done_d;

  // Operand signedness decoded from funct3.
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  assign a_sgn = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign b_sgn = op[2] ? ~op[0] : ~op[1];
  assign a_neg = a_sgn & operand_a[XLEN-1];
  assign b_neg = b_sgn & operand_b[XLEN-1];
  assign a_mag = a_neg ? -operand_a : operand_a;
  assign b_mag = b_neg ? -operand_b : operand_b;

  // Multiply step: lo holds the multiplier, product shifts in from the top.
  logic [XLEN:0] sum;
  assign sum = {1'b0, hi_q}
             + {1'b0, (lo_q[0] ? b_q : '0)};

  // Restoring divide step: lo holds the dividend, quotient shifts in at bit 0.
  // The partial remainder stays below the divisor, so the difference fits XLEN.
  logic [XLEN:0]   shf;
  logic [XLEN-1:0] dif;
  logic            ge;
  assign shf = {hi_q, lo_q[XLEN-1]};
  assign ge  = shf >= {1'b0, b_q};
  assign dif = shf[XLEN-1:0] - b_q;

  // Sign correction. A zero divisor yields an all-ones quotient magnitude
  // and the untouched dividend as remainder; neg_q is suppressed for it.
  logic [2*XLEN-1:0] prod_c;
  logic [XLEN-1:0]   q_c, r_c, fix_val;
  assign prod_c = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign q_c    = neg_q ? -lo_q : lo_q;
  assign r_c    = nrem_q ? -hi_q : hi_q;

  always_comb begin
    fix_val = q_c;
    unique case (1'b1)
      !op_q[2] && op_q[1:0] == 2'b00: fix_val = prod_c[XLEN-1:0];
      !op_q[2] && op_q[1:0] != 2'b00: fix_val = prod_c[2*XLEN-1:XLEN];
      op_q[2] && op_q[1]:             fix_val = r_c;
      op_q[2] && !op_q[1]:            fix_val = q_c;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    nrem_d   = nrem_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    res_d    = res_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !kill && !done_q) begin
          state_d = S_CALC;
          cnt_d   = '0;
          op_d    = op;
          hi_d    = '0;
          lo_d    = op[2] ? a_mag : b_mag;
          b_d     = op[2] ? b_mag : a_mag;
          neg_d   = (a_neg ^ b_neg)
                  & (~op[2] | (operand_b != '0));
          nrem_d  = a_neg;
          rd_d    = rd_in;
        end
      end
      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (op_q[2]) begin
            hi_d = ge ? dif : shf[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ge};
          end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          lo_d    = fix_val;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        res_d    = lo_q;
        rd_out_d = rd_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      nrem_q   <= 1'b0;
      rd_q     <= '0;
      rd_out_q <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      nrem_q   <= nrem_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      res_q    <= res_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE) | done_q;
  assign done   = done_q;
  assign result = res_q;
  assign rd_out = rd_out_q;
  assign wb_en  = done_q & (rd_out_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed RV32M ops
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        kill;
  logic        busy, done, wb_en;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int failures = 0;
  longint cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    longint      at;
  } exp_t;

  exp_t sb[$];
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  muldiv_unit #(.XLEN(32), .ADDR_W(5)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .op(op),
    .operand_a(a), .operand_b(b), .rd_in(rd_in), .kill(kill),
    .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .wb_en(wb_en)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    logic [63:0] p;
    logic [31:0] r;
    logic ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p = '0;
    r = '0;
    case (o)
      3'd0: begin p = ux * uy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: r = (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sx / sy);
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: r = (y == 0) ? x : ovf ? 32'h0 : 32'(sx % sy);
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge CLK) begin
    exp_t e;
    if (!Reset && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
        chk("wb_en", {31'b0, wb_en}, {31'b0, e.rd != 5'd0});
        chk("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
    if (!Reset && wb_en && !done) begin
      checks++;
      failures++;
      $display("FAIL wb_without_done actual=1 required=0");
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] r,
                       input bit track);
    int n = 0;
    @(negedge CLK);
    while (busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=busy required=idle");
      return;
    end
    op = o; a = x; b = y; rd_in = r; start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    if (track) begin
      sb.push_back('{ref_model(o, x, y), r, cyc + 34});
      last_res = ref_model(o, x, y);
      last_rd = r;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 required=1");
    end
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'($urandom_range(0, 15));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; start = 1'b0; kill = 1'b0;
    op = '0; a = '0; b = '0; rd_in = '0;
    last_res = '0; last_rd = '0;
    #12;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    chk("reset_wb_en", {31'b0, wb_en}, 32'h0);
    @(negedge CLK);
    Reset = 1'b0;

    // Reset in mid-calculation discards the operation.
    issue(3'd0, 32'd3, 32'd4, 5'd1, 1'b0);
    repeat (10) @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_rd_out", {27'b0, rd_out}, 32'h0);
    @(negedge CLK);
    Reset = 1'b0;

    // Directed cases.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 1'b1);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
    issue(3'd5, 32'd100, 32'd7, 5'd11, 1'b1);
    issue(3'd7, 32'd100, 32'd7, 5'd12, 1'b1);
    issue(3'd5, 32'd5, 32'd0, 5'd13, 1'b1);
    issue(3'd7, 32'd5, 32'd0, 5'd14, 1'b1);
    issue(3'd4, 32'd5, 32'd0, 5'd15, 1'b1);
    issue(3'd6, 32'hFFFF_FFFB, 32'd0, 5'd16, 1'b1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1'b1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1'b1);
    issue(3'd0, 32'd9, 32'd9, 5'd0, 1'b1);

    // Starts while busy are ignored.
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd19, 1'b1);
    repeat (5) begin
      @(negedge CLK);
      chk("busy_hold", {31'b0, busy}, 32'h1);
      start = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
      @(negedge CLK);
      start = 1'b0;
    end
    drain();

    // Kill mid-calculation: no done, outputs held.
    issue(3'd0, 32'd11, 32'd13, 5'd20, 1'b0);
    repeat (19) @(negedge CLK);
    kill = 1'b1;
    @(posedge CLK);
    #1 kill = 1'b0;
    @(negedge CLK);
    chk("kill_busy", {31'b0, busy}, 32'h0);
    chk("kill_result", result, last_res);
    chk("kill_rd_out", {27'b0, rd_out}, {27'b0, last_rd});
    repeat (40) @(negedge CLK);

    // Kill in idle blocks a same-cycle start.
    start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1; rd_in = 5'd3;
    @(posedge CLK);
    #1 begin start = 1'b0; kill = 1'b0; end
    @(negedge CLK);
    chk("kill_idle_busy", {31'b0, busy}, 32'h0);

    // Start in the done cycle is ignored; kill there has no effect.
    issue(3'd5, 32'd1000, 32'd3, 5'd21, 1'b1);
    wait_done();
    start = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2; rd_in = 5'd4;
    @(posedge CLK);
    #1 begin start = 1'b0; kill = 1'b0; end
    @(negedge CLK);
    chk("done_start_ign", {31'b0, busy}, 32'h0);
    issue(3'd7, 32'd1000, 32'd3, 5'd22, 1'b1);

    // Random traffic.
    for (int i = 0; i < 50; i++)
      issue(3'($urandom), pick(), pick(), 5'($urandom), 1'b1);
    drain();
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit, directly downstream of RegisterFile.
- Consumes ReadData1/ReadData2 as operand_a/operand_b and returns a result plus a write-enable that drives RegisterFile WriteData/WriteAddress/RegWrite through the writeback mux.
- Computes one result bit per cycle with a fixed latency, so stall logic is a plain busy check.

Parameters:
- XLEN, 32, operand/result width (equals REG_WIDTH of RISCV_PKG).
- ADDR_W, 5, destination register address width (equals ADDRESS_PORT_WIDTH).

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  in  XLEN  rs1 value (dividend / multiplicand).
- operand_b  in  XLEN  rs2 value (divisor / multiplier).
- rd_in  in  ADDR_W  destination register.
- kill  in  1  synchronous abort (pipeline flush).
- busy  out  1  high from the cycle after acceptance through the done cycle inclusive.
- done  out  1  one-cycle result-valid pulse.
- result  out  XLEN  result; held until the next acceptance.
- rd_out  out  ADDR_W  latched rd_in; held with result.
- wb_en  out  1  done && (rd_out != 0); drives RegWrite.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, done, wb_en, result and rd_out are all 0; internal registers cleared. Reset mid-operation discards the operation with no done.
- States:
  - IDLE: start=1 && kill=0 at edge E0 latches op, operands, rd_in; clears the counter; goes to CALC.
  - CALC: runs XLEN cycles (E1..EXLEN).
    - Multiply: shift-add on the magnitudes.
    - Divide: restoring shift-subtract on the magnitudes.
    - Counter counts 0..XLEN-1.
  - FIX (EXLEN+1): applies sign correction and special cases.
  - DONE (EXLEN+2): result registered; done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: done is high in the cycle following edge E0+XLEN+2 (34 cycles for XLEN=32). Latency is identical for all ops, including the special cases.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: operand_a signed, operand_b unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
  - Magnitudes are taken at acceptance; the 2·XLEN-bit product is negated when the signs differ.
- Outputs:
  - MUL: low XLEN bits of the product.
  - MULH*: high XLEN bits of the product.
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign.
- Divide by zero: DIV/DIVU give all-ones; REM/REMU give operand_a.
- Signed overflow (DIV/REM with operand_a = 0x80000000 and operand_b = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Boundary conditions:
  - start while busy=1: ignored, no queueing.
  - start in the DONE cycle: ignored; the unit accepts again on the following cycle.
  - kill=1 in CALC or FIX: next edge goes to IDLE; done/wb_en never pulse; result/rd_out keep their previous values.
  - kill in IDLE: blocks a same-cycle start.
  - kill in the DONE cycle: no effect; the result still writes back.
  - rd_in=0: the op runs and done pulses, but wb_en stays 0.
- Operand inputs need not be held after acceptance.

Test Plan:
- Reset asserted mid-CALC (cycle 10) -> busy/done/result go to 0 immediately. A new start after release produces done after exactly 34 cycles.
- MUL 7 × 0xFFFFFFFD, rd=5 -> result 0xFFFFFFEB, rd_out=5, wb_en=1. done pulses once, 34 cycles after acceptance.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM of the same -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF. REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same -> 0. All take the full 34-cycle latency.
- Second start pulses while busy=1 are ignored; kill at cycle 20 -> no done, busy drops next cycle. MUL with rd=0 -> done=1, wb_en=0.
